sn_r_packetizer: RTL

SN_R_PACKETIZER -- requirements
Module: sn_r_packetizer

---
 rtl/sn_pkg.sv | 47 ++++
 rtl/sn_sync_fifo.sv | 59 +++++
 rtl/sn_r_packetizer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/sn_pkg.sv
// Shared widths, payload bit offsets and record types for the R-channel packetizer.
package sn_pkg;

  localparam int ID_W    = 11;
  localparam int DATA_W  = 64;
  localparam int RESP_W  = 2;
  localparam int USER_W  = 4;
  localparam int LEN_W   = 8;
  localparam int SRCID_W = 2;
  localparam int FLIT_W  = 82;

  localparam int LAST_OFF = 0;
  localparam int USER_OFF = 1;
  localparam int RESP_OFF = 5;
  localparam int DATA_OFF = 7;
  localparam int ID_OFF   = 71;

  typedef struct packed {
    logic [LEN_W-1:0]   len;
    logic [SRCID_W-1:0] srcid;
  } trk_entry_t;

  typedef struct packed {
    logic               head;
    logic               tail;
    logic [SRCID_W-1:0] tgtid;
    logic [FLIT_W-1:0]  payload;
  } flit_entry_t;

  function automatic logic [FLIT_W-1:0] pack_beat(
    input logic [ID_W-1:0]   id,
    input logic [DATA_W-1:0] data,
    input logic [RESP_W-1:0] resp,
    input logic [USER_W-1:0] user,
    input logic              last
  );
    logic [FLIT_W-1:0] f;
    f = '0;
    f[ID_OFF +: ID_W]     = id;
    f[DATA_OFF +: DATA_W] = data;
    f[RESP_OFF +: RESP_W] = resp;
    f[USER_OFF +: USER_W] = user;
    f[LAST_OFF]           = last;
    return f;
  endfunction

endpackage

// File: rtl/sn_sync_fifo.sv
// Single-clock FIFO with power-of-2 depth; a push into a full FIFO is taken
// only when a pop happens in the same cycle.
module sn_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == FULL_CNT);
  assign w_doPop  = i_pop && !o_empty;
  assign w_doPush = i_push && (!o_full || w_doPop);
  assign o_dout   = r_mem[r_rdPtr];

  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sn_r_packetizer.sv
// AXI R-channel to NoC flit packetizer with an in-order burst tracker.
// Optional burst-length checking is enabled by defining SN_R_BEAT_CHECK_EN.
module sn_r_packetizer
  import sn_pkg::*;
#(
  parameter int TRK_DEPTH = 4,
  parameter int OUT_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               ar_ready,
  input  logic               ar_push,
  input  logic [LEN_W-1:0]   ar_len,
  input  logic [SRCID_W-1:0] ar_srcid,
  input  logic               RVALID,
  output logic               RREADY,
  input  logic [ID_W-1:0]    RID,
  input  logic [DATA_W-1:0]  RDATA,
  input  logic [RESP_W-1:0]  RRESP,
  input  logic               RLAST,
  input  logic [USER_W-1:0]  RUSER,
  input  logic               r_ready,
  output logic               r_valid,
  output logic               r_head,
  output logic               r_tail,
  output logic [FLIT_W-1:0]  r_payload,
  output logic [SRCID_W-1:0] r_tgtid,
  output logic               len_err
);

  trk_entry_t  w_trkDin;
  trk_entry_t  w_trkHead;
  logic        w_trkFull;
  logic        w_trkEmpty;
  logic        w_trkPush;
  logic        w_trkPop;
  flit_entry_t w_outDin;
  flit_entry_t w_outHead;
  logic        w_outFull;
  logic        w_outEmpty;
  logic        w_outPop;
  logic        w_accept;
  logic        r_headArm;
  logic [LEN_W-1:0] r_beatCnt;

  assign ar_ready  = !w_trkFull;
  assign w_trkPush = ar_push && ar_ready;
  assign w_trkDin  = '{len: ar_len, srcid: ar_srcid};

  assign RREADY   = !w_trkEmpty && !w_outFull;
  assign w_accept = RVALID && RREADY;
  assign w_trkPop = w_accept && RLAST;

  sn_sync_fifo #(
    .WIDTH($bits(trk_entry_t)),
    .DEPTH(TRK_DEPTH)
  ) u_tracker (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_trkPush),
    .i_pop  (w_trkPop),
    .i_din  (w_trkDin),
    .o_dout (w_trkHead),
    .o_full (w_trkFull),
    .o_empty(w_trkEmpty)
  );

  assign w_outDin = '{head:    r_headArm,
                      tail:    RLAST,
                      tgtid:   w_trkHead.srcid,
                      payload: pack_beat(RID, RDATA, RRESP, RUSER, RLAST)};
  assign w_outPop = r_ready && !w_outEmpty;

  sn_sync_fifo #(
    .WIDTH($bits(flit_entry_t)),
    .DEPTH(OUT_DEPTH)
  ) u_outbuf (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_accept),
    .i_pop  (w_outPop),
    .i_din  (w_outDin),
    .o_dout (w_outHead),
    .o_full (w_outFull),
    .o_empty(w_outEmpty)
  );

  // Buffer storage is not reset, so flit fields are forced to zero whenever nothing is presented.
  assign r_valid   = !w_outEmpty;
  assign r_head    = r_valid && w_outHead.head;
  assign r_tail    = r_valid && w_outHead.tail;
  assign r_payload = r_valid ? w_outHead.payload : '0;
  assign r_tgtid   = r_valid ? w_outHead.tgtid : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_headArm <= 1'b1;
      r_beatCnt <= '0;
    end else if (w_accept) begin
      r_headArm <= RLAST;
      r_beatCnt <= RLAST ? '0 : r_beatCnt + 1'b1;
    end
  end

`ifdef SN_R_BEAT_CHECK_EN
  logic r_lenErr;
  logic w_lenBad;

  // r_beatCnt counts beats before the current one, so beat number len+1 sees r_beatCnt == len.
  assign w_lenBad = w_accept && (RLAST ? (r_beatCnt != w_trkHead.len)
                                       : (r_beatCnt == w_trkHead.len));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lenErr <= 1'b0;
    end else if (w_lenBad) begin
      r_lenErr <= 1'b1;
    end
  end

  assign len_err = r_lenErr;
`else
  logic w_unusedLen;
  assign w_unusedLen = ^{r_beatCnt, w_trkHead.len};
  assign len_err     = 1'b0;
`endif

endmodule
